// File: rtl/pe_op_scheduler.sv
// pe_op_scheduler
// ---------------------------------------------------------------------------
// Purpose: takes one instruction per cycle from the instruction source over a
// valid/ready handshake and drives the operand-fetch, PE-opcode and
// result-store controls. It stalls while the PE works on an op: one stage-1
// strobe ends an element-wise op, and PE_ELEMENTS stage-2 strobes end a DOTP.
// It also provides an operand/result hazard interlock, a completion timeout
// that halts with an error, and a wrapping counter of issued PE ops.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inst_valid/inst     instruction offer  ({addr, opcode})
//   inst_ready          high only in RUN; accept = inst_valid & inst_ready
//   pe_stage_1_valid    PE stage-1 completion strobe
//   pe_stage_2_valid    PE stage-2 element strobe
//   load_a/load_b       one-cycle operand fetch pulses, with fetch_addr
//   pe_opcode/pe_issue  PE opcode (0 = idle) qualified by a one-cycle pulse
//   store_result        one-cycle result write pulse, with res_addr
//   busy                waiting on PE completion
//   stop                halted (STOP or error) until reset
//   err                 sticky error flag
//   issue_cnt           number of PE ops issued (wraps)
// All outputs are registered.
// INST_LEN must equal OPCODE_LEN + ADDR_LEN.
// ---------------------------------------------------------------------------
module pe_op_scheduler #(
  parameter int OPCODE_LEN    = 4,
  parameter int ADDR_LEN      = 8,
  parameter int INST_LEN      = 12,
  parameter int PE_OPCODE_LEN = 3,
  parameter int PE_ELEMENTS   = 4,
  parameter int TIMEOUT       = 64,
  parameter int CNT_LEN       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_valid,
  input  logic [INST_LEN-1:0]      inst,
  output logic                     inst_ready,
  input  logic                     pe_stage_1_valid,
  input  logic                     pe_stage_2_valid,
  output logic                     load_a,
  output logic                     load_b,
  output logic [ADDR_LEN-1:0]      fetch_addr,
  output logic [PE_OPCODE_LEN-1:0] pe_opcode,
  output logic                     pe_issue,
  output logic                     store_result,
  output logic [ADDR_LEN-1:0]      res_addr,
  output logic                     busy,
  output logic                     stop,
  output logic                     err,
  output logic [CNT_LEN-1:0]       issue_cnt
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_S1 = 2'd1,
    S_WAIT_S2 = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [OPCODE_LEN-1:0] OP_NOOP      = OPCODE_LEN'(0);
  localparam logic [OPCODE_LEN-1:0] OP_FETCH_A   = OPCODE_LEN'(1);
  localparam logic [OPCODE_LEN-1:0] OP_FETCH_B   = OPCODE_LEN'(2);
  localparam logic [OPCODE_LEN-1:0] OP_ADD       = OPCODE_LEN'(3);
  localparam logic [OPCODE_LEN-1:0] OP_SUB       = OPCODE_LEN'(4);
  localparam logic [OPCODE_LEN-1:0] OP_MUL       = OPCODE_LEN'(5);
  localparam logic [OPCODE_LEN-1:0] OP_DOTP      = OPCODE_LEN'(6);
  localparam logic [OPCODE_LEN-1:0] OP_ST_S1     = OPCODE_LEN'(7);
  localparam logic [OPCODE_LEN-1:0] OP_ST_S2     = OPCODE_LEN'(8);
  localparam logic [OPCODE_LEN-1:0] OP_STORE_RES = OPCODE_LEN'(9);
  localparam logic [OPCODE_LEN-1:0] OP_STOP      = OPCODE_LEN'(10);

  localparam logic [PE_OPCODE_LEN-1:0] PE_ADD       = PE_OPCODE_LEN'(1);
  localparam logic [PE_OPCODE_LEN-1:0] PE_SUB       = PE_OPCODE_LEN'(2);
  localparam logic [PE_OPCODE_LEN-1:0] PE_MUL       = PE_OPCODE_LEN'(3);
  localparam logic [PE_OPCODE_LEN-1:0] PE_DOTP      = PE_OPCODE_LEN'(4);
  localparam logic [PE_OPCODE_LEN-1:0] PE_ST_S1     = PE_OPCODE_LEN'(5);
  localparam logic [PE_OPCODE_LEN-1:0] PE_ST_S2     = PE_OPCODE_LEN'(6);
  localparam logic [PE_OPCODE_LEN-1:0] PE_STORE_RES = PE_OPCODE_LEN'(7);

  // The wait counter holds the number of wait cycles already elapsed, so the
  // TIMEOUT-th wait cycle is the one where it reads TIMEOUT-1.
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ECNT_W = (PE_ELEMENTS > 1) ? $clog2(PE_ELEMENTS) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [ECNT_W-1:0] ELEM_LAST = ECNT_W'(PE_ELEMENTS - 1);

  logic [OPCODE_LEN-1:0] opcode;
  logic [ADDR_LEN-1:0]   addr;
  assign opcode = inst[OPCODE_LEN-1:0];
  assign addr   = inst[OPCODE_LEN +: ADDR_LEN];

  function automatic logic [PE_OPCODE_LEN-1:0] pe_code(input logic [OPCODE_LEN-1:0] op);
    case (op)
      OP_ADD:  pe_code = PE_ADD;
      OP_SUB:  pe_code = PE_SUB;
      OP_MUL:  pe_code = PE_MUL;
      OP_DOTP: pe_code = PE_DOTP;
      OP_ST_S1: pe_code = PE_ST_S1;
      OP_ST_S2: pe_code = PE_ST_S2;
      default: pe_code = '0;
    endcase
  endfunction

  state_t                  state_q;
  logic [WCNT_W-1:0]       wait_cnt_q;
  logic [ECNT_W-1:0]       elem_cnt_q;
  logic                    a_ok_q, b_ok_q, res_ok_q;
  logic                    inst_ready_q, busy_q, stop_q, err_q;
  logic                    load_a_q, load_b_q, pe_issue_q, store_result_q;
  logic [ADDR_LEN-1:0]     fetch_addr_q, res_addr_q;
  logic [PE_OPCODE_LEN-1:0] pe_opcode_q;
  logic [CNT_LEN-1:0]      issue_cnt_q;

  // Single-process FSM: inst_ready/busy/stop are updated together with every
  // state change so they always reflect the state the FSM is entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_RUN;
      wait_cnt_q     <= '0;
      elem_cnt_q     <= '0;
      a_ok_q         <= 1'b0;
      b_ok_q         <= 1'b0;
      res_ok_q       <= 1'b0;
      inst_ready_q   <= 1'b1;
      busy_q         <= 1'b0;
      stop_q         <= 1'b0;
      err_q          <= 1'b0;
      load_a_q       <= 1'b0;
      load_b_q       <= 1'b0;
      pe_issue_q     <= 1'b0;
      store_result_q <= 1'b0;
      fetch_addr_q   <= '0;
      res_addr_q     <= '0;
      pe_opcode_q    <= '0;
      issue_cnt_q    <= '0;
    end else begin
      // Pulses default low; pe_opcode is idle whenever nothing is issued.
      load_a_q       <= 1'b0;
      load_b_q       <= 1'b0;
      pe_issue_q     <= 1'b0;
      store_result_q <= 1'b0;
      pe_opcode_q    <= '0;

      case (state_q)
        S_RUN: begin
          if (inst_valid) begin
            case (opcode)
              OP_NOOP: ;
              OP_FETCH_A: begin
                load_a_q     <= 1'b1;
                fetch_addr_q <= addr;
                a_ok_q       <= 1'b1;
              end
              OP_FETCH_B: begin
                load_b_q     <= 1'b1;
                fetch_addr_q <= addr;
                b_ok_q       <= 1'b1;
              end
              OP_ADD, OP_SUB, OP_MUL, OP_DOTP: begin
                if (!(a_ok_q && b_ok_q)) begin
                  err_q        <= 1'b1;
                  state_q      <= S_HALT;
                  inst_ready_q <= 1'b0;
                  stop_q       <= 1'b1;
                end else begin
                  pe_issue_q   <= 1'b1;
                  pe_opcode_q  <= pe_code(opcode);
                  issue_cnt_q  <= issue_cnt_q + 1'b1;
                  wait_cnt_q   <= '0;
                  elem_cnt_q   <= '0;
                  state_q      <= (opcode == OP_DOTP) ? S_WAIT_S2 : S_WAIT_S1;
                  inst_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
                end
              end
              OP_ST_S1, OP_ST_S2: begin
                pe_issue_q  <= 1'b1;
                pe_opcode_q <= pe_code(opcode);
                issue_cnt_q <= issue_cnt_q + 1'b1;
              end
              OP_STORE_RES: begin
                if (!res_ok_q) begin
                  err_q        <= 1'b1;
                  state_q      <= S_HALT;
                  inst_ready_q <= 1'b0;
                  stop_q       <= 1'b1;
                end else begin
                  store_result_q <= 1'b1;
                  res_addr_q     <= addr;
                  pe_issue_q     <= 1'b1;
                  pe_opcode_q    <= PE_STORE_RES;
                  issue_cnt_q    <= issue_cnt_q + 1'b1;
                  res_ok_q       <= 1'b0;
                end
              end
              OP_STOP: begin
                state_q      <= S_HALT;
                inst_ready_q <= 1'b0;
                stop_q       <= 1'b1;
              end
              // Illegal opcodes flag the error but execution continues.
              default: err_q <= 1'b1;
            endcase
          end
        end

        S_WAIT_S1: begin
          // Completion is checked before the timeout so it wins a tie.
          if (pe_stage_1_valid) begin
            res_ok_q     <= 1'b1;
            state_q      <= S_RUN;
            inst_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            stop_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_WAIT_S2: begin
          // Only the final element strobe counts as completion; an earlier
          // strobe landing on the timeout cycle does not rescue the op.
          if (pe_stage_2_valid && (elem_cnt_q == ELEM_LAST)) begin
            res_ok_q     <= 1'b1;
            state_q      <= S_RUN;
            inst_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            stop_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (pe_stage_2_valid) elem_cnt_q <= elem_cnt_q + 1'b1;
          end
        end

        default: ; // S_HALT: held until reset
      endcase
    end
  end

  assign inst_ready   = inst_ready_q;
  assign load_a       = load_a_q;
  assign load_b       = load_b_q;
  assign fetch_addr   = fetch_addr_q;
  assign pe_opcode    = pe_opcode_q;
  assign pe_issue     = pe_issue_q;
  assign store_result = store_result_q;
  assign res_addr     = res_addr_q;
  assign busy         = busy_q;
  assign stop         = stop_q;
  assign err          = err_q;
  assign issue_cnt    = issue_cnt_q;

endmodule

// File: tb/tb_pe_op_scheduler.sv
// Testbench for pe_op_scheduler: directed scenarios followed by randomized
// stimulus, every cycle checked against a transaction-level reference model.
module tb_pe_op_scheduler;

  localparam int TIMEOUT     = 64;
  localparam int PE_ELEMENTS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [11:0] inst = '0;
  logic        inst_ready;
  logic        pe_stage_1_valid = 1'b0;
  logic        pe_stage_2_valid = 1'b0;
  logic        load_a, load_b, pe_issue, store_result, busy, stop, err;
  logic [7:0]  fetch_addr, res_addr;
  logic [2:0]  pe_opcode;
  logic [15:0] issue_cnt;

  pe_op_scheduler dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .pe_stage_1_valid(pe_stage_1_valid),
    .pe_stage_2_valid(pe_stage_2_valid), .load_a(load_a), .load_b(load_b),
    .fetch_addr(fetch_addr), .pe_opcode(pe_opcode), .pe_issue(pe_issue),
    .store_result(store_result), .res_addr(res_addr), .busy(busy),
    .stop(stop), .err(err), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Progress is tracked as "strobes still owed" and an absolute deadline
  // edge number rather than as a state machine.
  int cyc = 0;
  bit halted, a_ok, b_ok, res_ok, e_err, after_rst;
  int wait_kind;      // 0 none, 1 waiting on stage-1, 2 waiting on stage-2
  int strobes_left;
  int deadline;
  int issued;
  bit e_load_a, e_load_b, e_issue, e_store;
  int e_op, e_faddr, e_raddr;

  function automatic int pe_map(input int op);
    case (op)
      3: return 1; 4: return 2; 5: return 3; 6: return 4;
      7: return 5; 8: return 6; 9: return 7;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int op, ad;
    bit strobe;
    cyc++;
    e_load_a = 0; e_load_b = 0; e_issue = 0; e_store = 0; e_op = 0;
    after_rst = 0;
    if (rst) begin
      halted = 0; a_ok = 0; b_ok = 0; res_ok = 0; e_err = 0; wait_kind = 0;
      issued = 0; e_faddr = 0; e_raddr = 0; after_rst = 1;
      return;
    end
    if (halted) return;
    if (wait_kind != 0) begin
      strobe = (wait_kind == 1) ? pe_stage_1_valid : pe_stage_2_valid;
      if (strobe) strobes_left--;
      if (strobes_left == 0) begin
        wait_kind = 0; res_ok = 1;
      end else if (cyc == deadline) begin
        wait_kind = 0; halted = 1; e_err = 1;
      end
      return;
    end
    if (!inst_valid) return;
    op = int'(inst[3:0]);
    ad = int'(inst[11:4]);
    $display("txn cyc=%0d op=%0d addr=%0d", cyc, op, ad);
    case (op)
      0: ;
      1: begin e_load_a = 1; e_faddr = ad; a_ok = 1; end
      2: begin e_load_b = 1; e_faddr = ad; b_ok = 1; end
      3, 4, 5, 6: begin
        if (!(a_ok && b_ok)) begin e_err = 1; halted = 1; end
        else begin
          e_issue = 1; e_op = pe_map(op); issued++;
          wait_kind = (op == 6) ? 2 : 1;
          strobes_left = (op == 6) ? PE_ELEMENTS : 1;
          deadline = cyc + TIMEOUT;
        end
      end
      7, 8: begin e_issue = 1; e_op = pe_map(op); issued++; end
      9: begin
        if (!res_ok) begin e_err = 1; halted = 1; end
        else begin
          e_store = 1; e_raddr = ad; e_issue = 1; e_op = 7; issued++; res_ok = 0;
        end
      end
      10: halted = 1;
      default: e_err = 1;
    endcase
  endtask

  task automatic compare_all();
    chk("inst_ready", inst_ready, (!halted && wait_kind == 0));
    chk("busy", busy, (wait_kind != 0));
    chk("stop", stop, halted);
    chk("err", err, e_err);
    chk("load_a", load_a, e_load_a);
    chk("load_b", load_b, e_load_b);
    if (e_load_a || e_load_b || after_rst) chk("fetch_addr", fetch_addr, e_faddr);
    chk("pe_issue", pe_issue, e_issue);
    chk("pe_opcode", pe_opcode, e_op);
    chk("store_result", store_result, e_store);
    if (e_store || after_rst) chk("res_addr", res_addr, e_raddr);
    chk("issue_cnt", issue_cnt, issued & 32'hFFFF);
  endtask

  // One clock: apply inputs, let the DUT and model consume them at the
  // rising edge, compare on the falling edge.
  task automatic cycle(input logic iv, input logic [11:0] ins,
                       input logic s1, input logic s2, input logic r);
    rst = r; inst_valid = iv; inst = ins;
    pe_stage_1_valid = s1; pe_stage_2_valid = s2;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [11:0] mk(input int op, input int ad);
    logic [3:0] o;
    logic [7:0] a;
    o = op[3:0];
    a = ad[7:0];
    return {a, o};
  endfunction

  task automatic idle();            cycle(1'b0, 12'h0, 1'b0, 1'b0, 1'b0); endtask
  task automatic send(input int op, input int ad); cycle(1'b1, mk(op, ad), 1'b0, 1'b0, 1'b0); endtask
  task automatic do_reset();        cycle(1'b0, 12'h0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    int k;
    int prob;
    int halt_run;
    logic iv, s1, s2, r;
    int op;

    do_reset(); do_reset();
    chk("reset_ready", inst_ready, 1);
    chk("reset_cnt", issue_cnt, 0);

    // Basic ADD
    send(1, 5);  chk("add_load_a", load_a, 1); chk("add_faddr_a", fetch_addr, 5);
    send(2, 7);  chk("add_load_b", load_b, 1); chk("add_faddr_b", fetch_addr, 7);
    send(3, 0);  chk("add_opcode", pe_opcode, 1); chk("add_busy", busy, 1);
    idle(); idle();
    cycle(1'b0, 12'h0, 1'b1, 1'b0, 1'b0);
    chk("add_done_busy", busy, 0);
    send(9, 9);  chk("add_store", store_result, 1); chk("add_res_addr", res_addr, 9);
    chk("add_issue_cnt", issue_cnt, 2);

    // DOTP with four stage-2 strobes two cycles apart
    send(6, 0);
    for (int i = 0; i < PE_ELEMENTS; i++) begin
      idle();
      chk("dotp_not_ready", inst_ready, 0);
      cycle(1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
    end
    chk("dotp_ready_after", inst_ready, 1);
    send(9, 33); chk("dotp_store", store_result, 1);

    // Operand and result hazards
    do_reset(); send(3, 0);
    chk("haz_err", err, 1); chk("haz_stop", stop, 1); chk("haz_issue", pe_issue, 0);
    do_reset(); send(9, 4);
    chk("haz_st_err", err, 1); chk("haz_st_stop", stop, 1);

    // Timeout latency
    do_reset(); send(1, 1); send(2, 2); send(5, 0);
    k = 0;
    while (!stop && k < 2 * TIMEOUT) begin idle(); k++; end
    chk("timeout_latency", k, TIMEOUT);
    chk("timeout_err", err, 1);
    // Strobe on the timeout cycle wins
    do_reset(); send(1, 1); send(2, 2); send(5, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle();
    cycle(1'b0, 12'h0, 1'b1, 1'b0, 1'b0);
    chk("tie_err", err, 0); chk("tie_ready", inst_ready, 1);

    // Illegal opcode then STOP, stray strobe in HALT
    do_reset(); send(13, 0);
    chk("illegal_err", err, 1); chk("illegal_ready", inst_ready, 1);
    send(10, 0);
    chk("stop_stop", stop, 1);
    cycle(1'b1, mk(1, 3), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    chk("halt_ready", inst_ready, 0); chk("halt_cnt", issue_cnt, 0);

    // Reset in the middle of a DOTP wait
    do_reset(); send(1, 1); send(2, 2); send(6, 0);
    idle(); cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
    idle(); cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
    do_reset();
    chk("mid_rst_busy", busy, 0); chk("mid_rst_cnt", issue_cnt, 0);
    chk("mid_rst_faddr", fetch_addr, 0); chk("mid_rst_op", pe_opcode, 0);
    cycle(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
    send(6, 0);
    chk("mid_rst_dotp_err", err, 1);

    // Randomized traffic
    do_reset();
    halt_run = 0;
    prob = 2;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: prob = 2;
          1: prob = 8;
          default: prob = 200;
        endcase
      end
      iv = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) op = $urandom_range(1, 2);
      else if ($urandom_range(0, 3) == 0) op = $urandom_range(3, 9);
      else op = $urandom_range(0, 15);
      s1 = ($urandom_range(0, prob - 1) == 0);
      s2 = ($urandom_range(0, prob - 1) == 0);
      halt_run = halted ? halt_run + 1 : 0;
      r = (halt_run > 4) || ($urandom_range(0, 299) == 0);
      cycle(iv, mk(op, $urandom_range(0, 255)), s1, s2, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
